// File: rtl/instruction_fetch_stage.sv
// instruction_fetch_stage
//
// Requester side of the instruction-memory interface. Owns the program
// counter, presents it as the word address to a combinational instruction
// memory, and captures the returned word together with PC+4 into the IF/ID
// pipeline register that feeds decode. Later pipeline stages can stall the
// stage, squash the word being captured, or redirect the PC with a jump
// (from ID) or a taken branch (from EX/MEM).
//
// Ports:
//   Clk              rising-edge clock
//   Reset            synchronous, active-high reset (highest priority)
//   Stall            hazard stall: hold PC, IF/ID and the fetch counter
//   Flush            squash the instruction being captured this cycle
//   Branch           taken-branch redirect, target in BranchTarget
//   BranchTarget     branch target byte address
//   Jump             jump redirect, target in JumpTarget (wins over Branch)
//   JumpTarget       jump target byte address
//   Instruction      word returned by the instruction memory for Address
//   Address          current PC, driven to the instruction memory
//   IFID_Instruction registered fetched instruction
//   IFID_PCPlus4     registered PC+4 of that instruction
//   IFID_Valid       IF/ID holds a real (non-squashed) instruction
//   FetchCount       number of instructions accepted into IF/ID
//   MisalignedFlag   sticky: a winning redirect target was not word aligned

module instruction_fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Stall,
   input  logic        Flush,
   input  logic        Branch,
   input  logic [31:0] BranchTarget,
   input  logic        Jump,
   input  logic [31:0] JumpTarget,
   input  logic [31:0] Instruction,
   output logic [31:0] Address,
   output logic [31:0] IFID_Instruction,
   output logic [31:0] IFID_PCPlus4,
   output logic        IFID_Valid,
   output logic [31:0] FetchCount,
   output logic        MisalignedFlag
);

   logic [31:0] pcReg;
   logic [31:0] pcPlus4;
   logic        redirect;
   logic [31:0] rawTarget;
   logic        targetMisaligned;
   logic [31:0] nextPc;
   logic        squash;
   logic        capture;

   // The memory address is the PC register and nothing else, so the memory
   // read always reflects the architectural PC of the word being fetched.
   assign Address = pcReg;

   // Redirect selection and next-PC choice. Jump comes from an earlier stage
   // than Branch but wins when both fire; the losing target is ignored
   // entirely, including for misalignment reporting. Redirects beat Stall
   // because the stalled fetch is down a wrong path anyway. The adder wraps
   // naturally at 32 bits.
   always_comb begin
      pcPlus4          = pcReg + 32'd4;
      redirect         = Jump | Branch;
      rawTarget        = Jump ? JumpTarget : BranchTarget;
      targetMisaligned = redirect && (rawTarget[1:0] != 2'b00);
      squash           = redirect | Flush;
      capture          = !squash && !Stall;
      nextPc           = pcPlus4;
      if (redirect) begin
         nextPc = {rawTarget[31:2], 2'b00};
      end else if (Stall) begin
         nextPc = pcReg;
      end
   end

   // Program counter register.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         pcReg <= RESET_PC;
      end else begin
         pcReg <= nextPc;
      end
   end

   // IF/ID pipeline register and fetch counter. A squash inserts a NOP
   // bubble and does not count; a stall freezes everything; otherwise the
   // memory word is accepted and counted.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         IFID_Instruction <= NOP_INSTR;
         IFID_PCPlus4     <= 32'd0;
         IFID_Valid       <= 1'b0;
         FetchCount       <= 32'd0;
      end else if (squash) begin
         IFID_Instruction <= NOP_INSTR;
         IFID_PCPlus4     <= 32'd0;
         IFID_Valid       <= 1'b0;
      end else if (capture) begin
         IFID_Instruction <= Instruction;
         IFID_PCPlus4     <= pcPlus4;
         IFID_Valid       <= 1'b1;
         FetchCount       <= FetchCount + 32'd1;
      end
   end

   // Sticky misalignment indicator; only Reset clears it.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         MisalignedFlag <= 1'b0;
      end else if (targetMisaligned) begin
         MisalignedFlag <= 1'b1;
      end
   end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// tb_instruction_fetch_stage
//
// Drives instruction_fetch_stage with a directed sequence followed by a
// randomized phase. Every cycle the stimulus process advances a behavioural
// model of the fetch stage and pushes the expected post-edge outputs into a
// scoreboard queue; an independent monitor pops one entry after each rising
// edge and compares it with the DUT outputs. The instruction memory is a
// combinational function of the address.

module tb_instruction_fetch_stage;

   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] instr;
      logic [31:0] pc4;
      logic        valid;
      logic [31:0] count;
      logic        flag;
   } expect_t;

   logic        Clk;
   logic        Reset;
   logic        Stall;
   logic        Flush;
   logic        Branch;
   logic [31:0] BranchTarget;
   logic        Jump;
   logic [31:0] JumpTarget;
   logic [31:0] Instruction;
   logic [31:0] Address;
   logic [31:0] IFID_Instruction;
   logic [31:0] IFID_PCPlus4;
   logic        IFID_Valid;
   logic [31:0] FetchCount;
   logic        MisalignedFlag;

   int      checks   = 0;
   int      failures = 0;
   expect_t model;
   expect_t sbQueue[$];

   instruction_fetch_stage #(
      .RESET_PC  (RESET_PC),
      .NOP_INSTR (NOP_INSTR)
   ) dut (
      .Clk              (Clk),
      .Reset            (Reset),
      .Stall            (Stall),
      .Flush            (Flush),
      .Branch           (Branch),
      .BranchTarget     (BranchTarget),
      .Jump             (Jump),
      .JumpTarget       (JumpTarget),
      .Instruction      (Instruction),
      .Address          (Address),
      .IFID_Instruction (IFID_Instruction),
      .IFID_PCPlus4     (IFID_PCPlus4),
      .IFID_Valid       (IFID_Valid),
      .FetchCount       (FetchCount),
      .MisalignedFlag   (MisalignedFlag)
   );

   // Small program at the bottom of memory, a scrambled pattern elsewhere.
   function automatic logic [31:0] memWord(input logic [31:0] addr);
      case (addr)
         32'h0:   memWord = 32'h2008_0005;
         32'h4:   memWord = 32'h2009_0003;
         32'h8:   memWord = 32'h0109_5020;
         32'hC:   memWord = 32'h0000_0000;
         default: memWord = (addr * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
      endcase
   endfunction

   assign Instruction = memWord(Address);

   // Free-running clock.
   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   // Global watchdog so the run can never hang.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   // Drive one cycle of inputs, advance the reference model by one edge and
   // queue its prediction, then wait for that edge.
   task automatic applyStimulus(input logic rst, input logic stl, input logic fl,
                                input logic br, input logic [31:0] bt,
                                input logic jp, input logic [31:0] jt);
      expect_t     nxt;
      logic [31:0] want;
      @(negedge Clk);
      Reset        = rst;
      Stall        = stl;
      Flush        = fl;
      Branch       = br;
      BranchTarget = bt;
      Jump         = jp;
      JumpTarget   = jt;
      nxt = model;
      if (rst) begin
         nxt.addr  = RESET_PC;
         nxt.instr = NOP_INSTR;
         nxt.pc4   = 32'd0;
         nxt.valid = 1'b0;
         nxt.count = 32'd0;
         nxt.flag  = 1'b0;
      end else begin
         want = jp ? jt : bt;
         if (jp || br) begin
            nxt.addr = want & ~32'd3;
            if ((want % 4) != 0) nxt.flag = 1'b1;
         end else if (!stl) begin
            nxt.addr = model.addr + 32'd4;
         end
         if (jp || br || fl) begin
            nxt.instr = NOP_INSTR;
            nxt.pc4   = 32'd0;
            nxt.valid = 1'b0;
         end else if (!stl) begin
            nxt.instr = memWord(model.addr);
            nxt.pc4   = model.addr + 32'd4;
            nxt.valid = 1'b1;
            nxt.count = model.count + 32'd1;
         end
      end
      model = nxt;
      sbQueue.push_back(nxt);
      @(posedge Clk);
   endtask

   task automatic runCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 32'h0, 0, 32'h0);
   endtask

   // Monitor: compare DUT outputs with the oldest prediction after each edge.
   initial begin
      expect_t e;
      forever begin
         @(posedge Clk);
         #1;
         if (sbQueue.size() > 0) begin
            e = sbQueue.pop_front();
            checkOutput("sb_address", Address, e.addr);
            checkOutput("sb_ifid_instr", IFID_Instruction, e.instr);
            checkOutput("sb_ifid_pc4", IFID_PCPlus4, e.pc4);
            checkOutput("sb_ifid_valid", {31'd0, IFID_Valid}, {31'd0, e.valid});
            checkOutput("sb_fetch_count", FetchCount, e.count);
            checkOutput("sb_misaligned", {31'd0, MisalignedFlag}, {31'd0, e.flag});
         end
      end
   end

   // Stimulus: directed scenarios with a few spot checks, then random traffic.
   initial begin
      int waitCycles;
      logic [31:0] bt;
      logic [31:0] jt;
      Reset = 1'b0; Stall = 1'b0; Flush = 1'b0; Branch = 1'b0; Jump = 1'b0;
      BranchTarget = 32'h0; JumpTarget = 32'h0;
      model = '{addr: 32'h0, instr: 32'h0, pc4: 32'h0, valid: 1'b0, count: 32'h0, flag: 1'b0};

      // Reset, then two fetches to reach PC = 8.
      applyStimulus(1, 0, 0, 0, 32'h0, 0, 32'h0);
      applyStimulus(1, 0, 0, 0, 32'h0, 0, 32'h0);
      #1;
      checkOutput("reset_address", Address, 32'h0);
      checkOutput("reset_valid", {31'd0, IFID_Valid}, 32'd0);
      checkOutput("reset_count", FetchCount, 32'd0);
      runCycles(1);
      #1;
      checkOutput("first_instr", IFID_Instruction, 32'h2008_0005);
      checkOutput("first_pc4", IFID_PCPlus4, 32'h4);
      runCycles(1);

      // Stall at PC = 8 for three cycles, then release.
      for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0, 32'h0, 0, 32'h0);
      #1;
      checkOutput("stall_address", Address, 32'h8);
      checkOutput("stall_instr", IFID_Instruction, 32'h2009_0003);
      checkOutput("stall_pc4", IFID_PCPlus4, 32'h8);
      checkOutput("stall_count", FetchCount, 32'd2);
      runCycles(1);
      #1;
      checkOutput("release_address", Address, 32'hC);

      // Branch together with stall at PC = 12: redirect wins.
      applyStimulus(0, 1, 0, 1, 32'h40, 0, 32'h0);
      #1;
      checkOutput("branch_stall_address", Address, 32'h40);
      checkOutput("branch_stall_valid", {31'd0, IFID_Valid}, 32'd0);
      checkOutput("branch_stall_count", FetchCount, 32'd3);

      // Jump and branch together: jump wins.
      applyStimulus(0, 0, 0, 1, 32'h80, 1, 32'h100);
      #1;
      checkOutput("jump_over_branch", Address, 32'h100);

      // Misaligned jump sets the sticky flag; misaligned losing branch does not matter.
      applyStimulus(0, 0, 0, 0, 32'h0, 1, 32'h103);
      #1;
      checkOutput("misaligned_address", Address, 32'h100);
      runCycles(10);
      #1;
      checkOutput("misaligned_sticky", {31'd0, MisalignedFlag}, 32'd1);

      // PC wrap, then reset in the middle of a stall.
      applyStimulus(0, 0, 0, 0, 32'h0, 1, 32'hFFFF_FFFC);
      runCycles(1);
      #1;
      checkOutput("pc_wrap_address", Address, 32'h0);
      checkOutput("pc_wrap_pc4", IFID_PCPlus4, 32'h0);
      applyStimulus(0, 1, 0, 0, 32'h0, 0, 32'h0);
      applyStimulus(1, 1, 1, 1, 32'h55, 1, 32'h77);
      #1;
      checkOutput("midstall_reset_flag", {31'd0, MisalignedFlag}, 32'd0);
      checkOutput("midstall_reset_address", Address, RESET_PC);

      // Losing misaligned branch target must not set the flag.
      applyStimulus(0, 0, 0, 1, 32'h31, 1, 32'h200);
      #1;
      checkOutput("losing_target_flag", {31'd0, MisalignedFlag}, 32'd0);

      // Free-run four cycles from reset.
      applyStimulus(1, 0, 0, 0, 32'h0, 0, 32'h0);
      applyStimulus(1, 0, 0, 0, 32'h0, 0, 32'h0);
      runCycles(4);
      #1;
      checkOutput("freerun_count", FetchCount, 32'd4);
      checkOutput("freerun_address", Address, 32'h10);

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         bt = $urandom;
         jt = $urandom;
         if ($urandom_range(0, 3) != 0) bt[1:0] = 2'b00;
         if ($urandom_range(0, 3) != 0) jt[1:0] = 2'b00;
         applyStimulus($urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0,
                       $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, bt,
                       $urandom_range(0, 11) == 0, jt);
      end

      // Let the monitor drain the scoreboard, bounded.
      waitCycles = 0;
      while (sbQueue.size() > 0 && waitCycles < 10) begin
         @(posedge Clk);
         #2;
         waitCycles++;
      end
      if (sbQueue.size() > 0) begin
         checks++;
         failures++;
         $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", sbQueue.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
